idt_cfg_ctrl: RTL and testbench



---
 rtl/idt_cfg_ctrl.sv | 154 +++++++++++++++
 tb/tb_idt_cfg_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idt_cfg_ctrl.sv
// Serial programmer for the IDT clock synthesizer: accepts a config request, shifts the 24-bit word, strobes, waits for PLL settle.
// Optional IDT_CFG_AUTOSTART_EN: program a built-in default word once after reset release without a request.
module idt_cfg_ctrl #(
    parameter int SCLK_HALF     = 4,
    parameter int STROBE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1000000
) (
    input  logic       osc_clk,
    input  logic       osc_reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [6:0] cfg_r,
    input  logic [8:0] cfg_v,
    input  logic [2:0] cfg_s,
    input  logic [1:0] cfg_f,
    input  logic       cfg_ttl,
    input  logic [1:0] cfg_c,
    output logic       busy,
    output logic       done,
    output logic       idt_sclk,
    output logic       idt_data,
    output logic       idt_strobe
);
    // state    | meaning
    // IDLE     | waiting for a request, cfg_ready high
    // SHIFT_LO | sclk low, data presents sr[23]
    // SHIFT_HI | sclk high, device samples data on the rising edge
    // STROBE   | load strobe high after the 24th bit
    // SETTLE   | waiting for the PLL to lock before reporting done
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, STROBE, SETTLE} state_t;

    localparam int M1   = (SCLK_HALF > STROBE_CYCLES) ? SCLK_HALF : STROBE_CYCLES;
    localparam int MAXC = (M1 > SETTLE_CYCLES) ? M1 : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HALF_LAST   = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [23:0]   sr, sr_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic          done_nxt, ready_nxt;
    logic          start;
    logic [23:0]   cfg_word, load_word;

    assign cfg_word = {cfg_c, cfg_ttl, cfg_f, cfg_s, cfg_v, cfg_r};

`ifdef IDT_CFG_AUTOSTART_EN
    // R=31, V=41, S=1, F=2, TTL=1, C=0: 148.5 MHz from a 100 MHz reference
    localparam logic [23:0] DEFAULT_WORD = {2'b00, 1'b1, 2'b10, 3'b001, 9'd41, 7'd31};
    localparam logic        READY_RST    = 1'b0;
    logic auto_pend, auto_pend_nxt;
    assign auto_pend_nxt = auto_pend && (state != IDLE);
    assign start         = auto_pend || (cfg_valid && cfg_ready);
    assign load_word     = auto_pend ? DEFAULT_WORD : cfg_word;
`else
    localparam logic READY_RST = 1'b1;
    assign start     = cfg_valid && cfg_ready;
    assign load_word = cfg_word;
`endif

    always_ff @(posedge osc_clk or posedge osc_reset) begin
        if (osc_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            cfg_ready  <= READY_RST;
            busy       <= 1'b0;
            done       <= 1'b0;
            idt_sclk   <= 1'b0;
            idt_data   <= 1'b0;
            idt_strobe <= 1'b0;
`ifdef IDT_CFG_AUTOSTART_EN
            auto_pend  <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            cfg_ready  <= ready_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            idt_sclk   <= (state_nxt == SHIFT_HI);
            idt_data   <= ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) && sr_nxt[23];
            idt_strobe <= (state_nxt == STROBE);
`ifdef IDT_CFG_AUTOSTART_EN
            auto_pend  <= auto_pend_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        bit_cnt_nxt = bit_cnt;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nxt      = load_word;
                    bit_cnt_nxt = '0;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT_HI;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SHIFT_HI: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    sr_nxt      = {sr[22:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    state_nxt   = (bit_cnt == 5'd23) ? STROBE : SHIFT_LO;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STROBE: begin
                if (cnt == STROBE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef IDT_CFG_AUTOSTART_EN
        ready_nxt = (state_nxt == IDLE) && !auto_pend_nxt;
`else
        ready_nxt = (state_nxt == IDLE);
`endif
    end
endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// Directed self-checking bench for idt_cfg_ctrl (default build, small timing parameters).
module tb_idt_cfg_ctrl;
    localparam int SH  = 2;
    localparam int ST  = 3;
    localparam int SE  = 10;
    localparam int LAT = 48 * SH + ST + SE;   // 109
    // {c=00, ttl=1, f=10, s=001, v=0_0010_1001, r=001_1111}
    localparam logic [23:0] WORD1 = 24'h31_149F;

    logic       osc_clk = 1'b0;
    logic       osc_reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [6:0] cfg_r;
    logic [8:0] cfg_v;
    logic [2:0] cfg_s;
    logic [1:0] cfg_f;
    logic       cfg_ttl;
    logic [1:0] cfg_c;
    logic       busy, done, idt_sclk, idt_data, idt_strobe;

    idt_cfg_ctrl #(.SCLK_HALF(SH), .STROBE_CYCLES(ST), .SETTLE_CYCLES(SE)) dut (
        .osc_clk(osc_clk), .osc_reset(osc_reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_r(cfg_r), .cfg_v(cfg_v), .cfg_s(cfg_s), .cfg_f(cfg_f), .cfg_ttl(cfg_ttl), .cfg_c(cfg_c),
        .busy(busy), .done(done), .idt_sclk(idt_sclk), .idt_data(idt_data), .idt_strobe(idt_strobe)
    );

    always #5 osc_clk = ~osc_clk;

    int n_assert = 0;
    int n_fail   = 0;

    int          cyc = 0;
    logic        prev_sclk = 1'b0, prev_data = 1'b0;
    logic [23:0] cap = '0;
    int rises = 0, strobe_cyc = 0, dones = 0, accs = 0, stab_err = 0;
    int last_acc = 0, prev_acc = 0, last_done = 0;

    always @(posedge osc_clk) cyc++;

    always @(negedge osc_clk) begin
        if (idt_sclk && !prev_sclk) begin
            cap = {cap[22:0], idt_data};
            rises++;
        end
        if (idt_sclk && prev_sclk && (idt_data !== prev_data)) stab_err++;
        if (idt_strobe) strobe_cyc++;
        if (done) begin
            dones++;
            last_done = cyc;
        end
        if (cfg_valid && cfg_ready && !osc_reset) begin
            accs++;
            prev_acc = last_acc;
            last_acc = cyc + 1;
        end
        prev_sclk = idt_sclk;
        prev_data = idt_data;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] r, input logic [8:0] v, input logic [2:0] s,
                        input logic [1:0] f, input logic t, input logic [1:0] c);
        @(posedge osc_clk); #1;
        cfg_r = r; cfg_v = v; cfg_s = s; cfg_f = f; cfg_ttl = t; cfg_c = c;
        cfg_valid = 1'b1;
        @(posedge osc_clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (dones < target && n < 400) begin
            @(posedge osc_clk);
            n++;
        end
        #1;
        check(tag, (dones >= target) ? 1 : 0, 1);
    endtask

    task automatic pulse_valid_junk();
        #1;
        cfg_r = '0; cfg_v = '0; cfg_s = '0; cfg_f = '0; cfg_ttl = 1'b0; cfg_c = '0;
        cfg_valid = 1'b1;
        @(posedge osc_clk); #1;
        cfg_valid = 1'b0;
    endtask

    int s_rise, s_str, s_done, s_acc, rdy_hi, n;

    initial begin
        osc_reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_r = '0; cfg_v = '0; cfg_s = '0; cfg_f = '0; cfg_ttl = 1'b0; cfg_c = '0;
        repeat (3) @(negedge osc_clk);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idt", int'({idt_sclk, idt_data, idt_strobe}), 0);
        @(posedge osc_clk); #1;
        osc_reset = 1'b0;
        repeat (2) @(posedge osc_clk);

        // basic transaction
        s_rise = rises; s_str = strobe_cyc; s_done = dones;
        send(7'd31, 9'd41, 3'd1, 2'd2, 1'b1, 2'd0);
        check("t1_busy_after_accept", int'(busy), 1);
        check("t1_ready_after_accept", int'(cfg_ready), 0);
        wait_done(s_done + 1, "t1_done_timeout");
        check("t1_word", int'(cap), int'(WORD1));
        check("t1_rises", rises - s_rise, 24);
        check("t1_strobe_cycles", strobe_cyc - s_str, ST);
        check("t1_latency", last_done - last_acc, LAT);
        check("t1_done_pulses", dones - s_done, 1);
        check("t1_ready_after_done", int'(cfg_ready), 1);
        check("t1_busy_after_done", int'(busy), 0);
        check("t1_stability", stab_err, 0);

        // cfg_valid held high: one accept per IDLE entry
        s_rise = rises; s_str = strobe_cyc; s_done = dones; s_acc = accs; rdy_hi = 0;
        @(posedge osc_clk); #1;
        cfg_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge osc_clk);
            if (cfg_ready) rdy_hi++;
        end
        @(posedge osc_clk); #1;
        cfg_valid = 1'b0;
        wait_done(s_done + 2, "t2_done_timeout");
        check("t2_accepts", accs - s_acc, 2);
        check("t2_accept_spacing", last_acc - prev_acc, LAT + 1);
        check("t2_ready_high_samples", rdy_hi, 2);
        check("t2_strobe_cycles", strobe_cyc - s_str, 2 * ST);
        check("t2_done_pulses", dones - s_done, 2);
        check("t2_rises", rises - s_rise, 48);

        // asynchronous reset during bit 10
        s_rise = rises; s_str = strobe_cyc;
        send(7'd31, 9'd41, 3'd1, 2'd2, 1'b1, 2'd0);
        n = 0;
        while (rises - s_rise < 10 && n < 200) begin
            @(posedge osc_clk);
            n++;
        end
        check("t3_reach_bit10", rises - s_rise, 10);
        @(negedge osc_clk); #2;
        osc_reset = 1'b1;
        #1;
        check("t3_async_idt", int'({idt_sclk, idt_data, idt_strobe}), 0);
        check("t3_async_busy", int'(busy), 0);
        check("t3_async_ready", int'(cfg_ready), 1);
        repeat (3) @(posedge osc_clk);
        #1;
        osc_reset = 1'b0;
        repeat (20) @(posedge osc_clk);
        check("t3_no_strobe", strobe_cyc - s_str, 0);

        // all-ones word after the aborted transfer
        s_rise = rises; s_done = dones; stab_err = 0;
        send(7'd127, 9'd511, 3'd7, 2'd3, 1'b1, 2'd3);
        wait_done(s_done + 1, "t4_done_timeout");
        check("t4_word", int'(cap), 32'h00FF_FFFF);
        check("t4_rises", rises - s_rise, 24);
        check("t4_stability", stab_err, 0);
        check("t4_latency", last_done - last_acc, LAT);

        // requests outside IDLE are ignored
        s_done = dones; s_acc = accs; stab_err = 0;
        send(7'd31, 9'd41, 3'd1, 2'd2, 1'b1, 2'd0);
        n = 0;
        while (!idt_sclk && n < 50) begin
            @(negedge osc_clk);
            n++;
        end
        check("t6_in_shift_hi", int'(idt_sclk), 1);
        pulse_valid_junk();
        n = 0;
        while (!idt_strobe && n < 200) begin
            @(negedge osc_clk);
            n++;
        end
        n = 0;
        while (idt_strobe && n < 20) begin
            @(negedge osc_clk);
            n++;
        end
        check("t6_in_settle", int'({busy, idt_strobe}), 2);
        pulse_valid_junk();
        wait_done(s_done + 1, "t6_done_timeout");
        check("t6_word", int'(cap), int'(WORD1));
        check("t6_latency", last_done - last_acc, LAT);
        check("t6_accepts", accs - s_acc, 1);
        repeat (20) @(posedge osc_clk);
        #1;
        check("t6_done_pulses", dones - s_done, 1);
        check("t6_idle_busy", int'(busy), 0);
        check("t6_stability", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
